// File: rtl/mips_pkg.sv
// Shared types and constants for the multiply/divide unit: op encodings,
// controller state enum, iteration count and operand-extension helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam int MULDIV_CYCLES = 32;
    localparam int CNT_W         = $clog2(MULDIV_CYCLES);

    function automatic logic [32:0] extend33(input logic [31:0] x, input logic sgn);
        return {sgn & x[31], x};
    endfunction

    // The largest magnitude of a 33-bit sign-extended word is 2^31, so it fits in 32 bits.
    function automatic logic [31:0] magnitude(input logic [32:0] v);
        logic [32:0] neg;
        neg = -v;
        return v[32] ? neg[31:0] : v[31:0];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift/add (multiply) and restoring shift/subtract (divide) engine.
// One step per cycle; the caller sequences load and step and post-processes signs.
module muldiv_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] acc
);

    logic [31:0] opb_q;
    logic [63:0] acc_q;
    logic [63:0] acc_next;
    logic [32:0] sum;
    logic [32:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        acc_next = acc_q;
        sum      = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
        diff     = acc_q[63:31] - {1'b0, opb_q};
        if (is_div) begin
            if (diff[32]) begin
                acc_next = {acc_q[62:0], 1'b0};
            end else begin
                acc_next = {diff[31:0], acc_q[30:0], 1'b1};
            end
        end else begin
            acc_next = {sum, acc_q[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
        if (!rst_n) begin
            acc_q <= '0;
            opb_q <= '0;
        end else if (load) begin
            acc_q <= {32'd0, opa};
            opb_q <= opb;
        end else if (step) begin
            acc_q <= acc_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS HI/LO multiply/divide controller: fixed-latency FSM, iteration counter,
// sign fix-up, HI/LO registers and pipeline stall request.
module muldiv_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mf_req,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    op_e              op_in;
    logic             sgn_op;
    logic             div_op;
    logic             accept;
    logic             is_div_q;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;
    logic [31:0]      a_q;
    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic [63:0]      acc;
    logic [63:0]      prod_fix;
    logic [31:0]      fix_hi;
    logic [31:0]      fix_lo;

    assign op_in  = op_e'(op);
    assign sgn_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign div_op = (op_in == OP_DIVU) || (op_in == OP_DIV);
    assign accept = (state == ST_IDLE) && start;
    assign mag_a  = magnitude(extend33(a, sgn_op));
    assign mag_b  = magnitude(extend33(b, sgn_op));

    assign busy  = (state != ST_IDLE);
    assign stall = busy & (start | mf_req);

    muldiv_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (state == ST_CALC),
        .is_div (is_div_q),
        .opa    (mag_a),
        .opb    (mag_b),
        .acc    (acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: if (cnt == CNT_W'(MULDIV_CYCLES - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Divide by zero bypasses the engine result so the outcome is independent of operand signs.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        fix_hi   = prod_fix[63:32];
        fix_lo   = prod_fix[31:0];
        if (is_div_q) begin
            fix_lo = neg_q ? -acc[31:0] : acc[31:0];
            fix_hi = neg_r ? -acc[63:32] : acc[63:32];
            if (zero_div) begin
                fix_hi = a_q;
                fix_lo = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div0     <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
            a_q      <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            if (accept) begin
                cnt      <= '0;
                is_div_q <= div_op;
                neg_q    <= sgn_op & (a[31] ^ b[31]);
                neg_r    <= sgn_op & a[31];
                zero_div <= div_op & (b == 32'd0);
                a_q      <= a;
            end
            if (state == ST_CALC) begin
                cnt <= cnt + 1'b1;
            end
            if (state == ST_FIX) begin
                hi   <= fix_hi;
                lo   <= fix_lo;
                done <= 1'b1;
                div0 <= zero_div;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: a driver pushes reference results, a monitor
// pops and compares on every done pulse, plus directed stall/reset/hold checks.
module tb_muldiv_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mf_req = 1'b0;
    logic        busy;
    logic        done;
    logic        div0;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .mf_req (mf_req),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int unsigned issue_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: plain integer arithmetic on the architectural definitions.
    function automatic exp_t ref_model(input op_e o, input logic [31:0] x, input logic [31:0] y,
                                       input string nm);
        exp_t        r;
        longint      sx;
        longint      sy;
        longint      q;
        longint      m;
        logic [63:0] p;
        r.name      = nm;
        r.div0      = 1'b0;
        r.issue_cyc = 0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (o)
            OP_MULTU: p = {32'd0, x} * {32'd0, y};
            OP_MULT:  p = sx * sy;
            default: begin
                if (y == 32'd0) begin
                    p      = {x, 32'hFFFF_FFFF};
                    r.div0 = 1'b1;
                end else if (o == OP_DIVU) begin
                    p = {x % y, x / y};
                end else begin
                    q = sx / sy;
                    m = sx % sy;
                    p = {m[31:0], q[31:0]};
                end
            end
        endcase
        r.hi = p[63:32];
        r.lo = p[31:0];
        return r;
    endfunction

    // Monitor: compare on done; otherwise HI/LO must hold their previous value.
    exp_t        mon_e;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;
    logic        prev_rst = 1'b0;

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
                check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
                check({mon_e.name, "_div0"}, 64'(div0), 64'(mon_e.div0));
                check({mon_e.name, "_latency"}, 64'(cyc - mon_e.issue_cyc), 64'(34));
            end
        end else if (rst_n && prev_rst) begin
            check("hold_hi", 64'(hi), 64'(prev_hi));
            check("hold_lo", 64'(lo), 64'(prev_lo));
        end
        prev_hi  = hi;
        prev_lo  = lo;
        prev_rst = rst_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input op_e o, input logic [31:0] x, input logic [31:0] y, input string nm);
        exp_t e;
        int   budget = 0;
        while (busy && budget < 100) begin
            tick();
            budget++;
        end
        if (busy) check("issue_timeout", 64'(busy), 64'(0));
        e = ref_model(o, x, y, nm);
        e.issue_cyc = cyc;
        sb.push_back(e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic drain();
        int budget = 0;
        while ((sb.size() != 0 || busy) && budget < 200) begin
            tick();
            budget++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int unsigned c;

    initial begin
        // Reset with a coincident start request, which must be ignored.
        rst_n  = 1'b0;
        start  = 1'b1;
        op     = OP_MULTU;
        a      = 32'h1234_5678;
        b      = 32'h9ABC_DEF0;
        mf_req = 1'b1;
        tick();
        tick();
        start  = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_div0", 64'(div0), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_stall_idle", 64'(stall), 64'(0));
        tick();
        mf_req = 1'b0;

        // Directed corner cases, issued back-to-back in each done cycle.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        issue(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
        issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
        issue(OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, "divu_big");
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        issue(OP_DIVU,  32'h0000_0005, 32'h0000_0000, "divu_zero");
        issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, "div_zero_neg");
        issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");
        drain();

        // Busy: second start and mf_req in cycle 5 stall and are ignored.
        c = cyc;
        issue(OP_MULTU, pick(), pick(), "multu_stall");
        repeat (4) tick();
        mf_req = 1'b1;
        start  = 1'b1;
        op     = OP_DIVU;
        a      = $urandom;
        b      = 32'd0;
        @(negedge clk);
        check("stall_cycle", 64'(cyc - c), 64'(5));
        check("stall_start_mf", 64'(stall), 64'(1));
        tick();
        start = 1'b0;
        @(negedge clk);
        check("stall_mf_only", 64'(stall), 64'(1));
        tick();
        mf_req = 1'b0;
        @(negedge clk);
        check("stall_none", 64'(stall), 64'(0));
        check("busy_mid", 64'(busy), 64'(1));
        tick();
        drain();
        mf_req = 1'b1;
        @(negedge clk);
        check("stall_mf_idle", 64'(stall), 64'(0));
        tick();
        mf_req = 1'b0;

        // Reset in cycle 10 of a divide discards it; a new op then completes.
        c = cyc;
        issue(OP_DIVU, pick(), pick(), "divu_killed");
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        tick();
        repeat (40) tick();
        issue(OP_DIVU, pick(), pick(), "divu_after_rst");
        drain();

        // Randomized traffic with corner-biased operands.
        for (int i = 0; i < 40; i++) begin
            issue(op_e'($urandom_range(0, 3)), pick(), pick(), $sformatf("rand%0d", i));
        end
        drain();
        repeat (3) tick();
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL expose: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL expose: start  in  1  issue request from EX stage; sampled only when busy=0.
REQ-004 SHALL expose: op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
REQ-005 SHALL expose: a  in  32  rs operand (multiplicand/dividend); sampled with start.
REQ-006 SHALL expose: b  in  32  rt operand (multiplier/divisor); sampled with start.
REQ-007 SHALL expose: mf_req  in  1  ID/EX stage wants MFHI/MFLO this cycle.
REQ-008 SHALL expose: busy  out  1  operation in flight.
REQ-009 SHALL expose: done  out  1  one-cycle pulse; hi/lo updated this cycle.
REQ-010 SHALL expose: div0  out  1  valid with done; divide with b=0.
REQ-011 SHALL expose: stall  out  1  pipeline hold request to hazard logic.
REQ-012 SHALL expose: hi  out  32  HI register; lo  out  32  LO register.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; start with busy=0 moves IDLE->CALC.
REQ-014 SHALL hold CALC exactly 32 cycles via 5-bit counter, then FIX for 1 cycle, then IDLE.
REQ-015 Latency: start in cycle 0 -> busy=1 cycles 1..33 -> done=1, busy=0, new hi/lo in cycle 34; fixed for every op.
REQ-016 Unsigned ops SHALL zero-extend operands to 33 bits; signed ops SHALL sign-extend, then take magnitudes.
REQ-017 Multiply SHALL be radix-2 shift-add over a 64-bit accumulator; hi=product[63:32], lo=product[31:0].
REQ-018 Divide SHALL be restoring, one quotient bit per CALC cycle; lo=quotient, hi=remainder.
REQ-019 FIX SHALL negate product if sign(a)^sign(b) (MULT), quotient if sign(a)^sign(b) and remainder if sign(a) (DIV).
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, no flag.
REQ-021 Divide with b=0 SHALL keep fixed latency and give hi=a, lo=0xFFFFFFFF, div0=1 with done.
REQ-022 start while busy=1 SHALL be ignored; operands not resampled.
REQ-023 stall SHALL equal busy & (start | mf_req); combinational, no extra cycle.
REQ-024 hi/lo SHALL change only in the done cycle or on reset; readable at any time.
REQ-025 start in the done cycle (busy=0) SHALL be accepted; back-to-back ops allowed.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, counter=0, hi=lo=0, busy=0, done=0, div0=0.
REQ-027 Reset mid-operation SHALL discard the in-flight result; no done pulse is produced.
REQ-028 start coincident with rst_n=0 SHALL be ignored.

Structure
REQ-029 Op encodings, FSM state enum and MULDIV_CYCLES=32 SHALL live in shared package mips_pkg.
REQ-030 Shift/add/subtract engine SHALL be one sub-module muldiv_core; muldiv_ctrl owns FSM, counter, sign fix-up, hi/lo.
REQ-031 No multiplier/divider primitives; RTL 120-400 lines total.

Verification
REQ-032 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> cycle 34: hi=0xFFFFFFFE, lo=0x00000001, done=1.
REQ-033 MULT a=0xFFFFFFFD b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5 b=0 -> hi=5, lo=0xFFFFFFFF, div0=1.
REQ-036 mf_req=1 and second start in cycle 5 of a MULTU -> stall=1 cycles 5, start ignored, first result unchanged at cycle 34.
REQ-037 rst_n=0 in cycle 10 of a DIVU -> next cycle busy=0, hi=lo=0, no done; new start then completes in 34 cycles.
